// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a start/busy/done handshake.
//
// Handshake: an operation is accepted at a rising edge where start=1 and busy=0;
// opcode, A and B are captured at that edge. start while busy=1 is dropped
// (no queueing). done pulses for exactly one cycle when C/err carry a new
// result; busy is 0 in that cycle so the next op may be accepted back-to-back.
//
// Single-cycle ops register C/done/err at the accept edge. mul (radix-2 Booth,
// signed) iterates WORD times. div (restoring on magnitudes + sign fix) iterates
// WORD times and then spends one FIX cycle; divide-by-zero goes straight to FIX.
//
// Optional feature macro: ALU_SEQ_DIV_EN
//   defined   - divider datapath and the DIV/FIX states are built.
//   undefined - opcode 00100 completes in one cycle with C=0, err=1.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-low reset
//   start      request, sampled only while busy=0
//   opcode[4:0] operation, sampled with start
//   A, B       WORD-bit operands, sampled with start
//   busy       operation in progress
//   done       one-cycle result pulse
//   err        divide-by-zero / unassigned or compiled-out opcode (valid with done)
//   C          2*WORD-bit result, held until the next done
//   dbg_state  current FSM state (IDLE=0, MUL=1, DIV=2, FIX=3)
module alu_seq #(
    parameter int WORD = 32,
    parameter int SHW  = $clog2(WORD)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [4:0]        opcode,
    input  logic [WORD-1:0]   A,
    input  logic [WORD-1:0]   B,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2*WORD-1:0] C,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB = 5'd2,
                           OP_MUL  = 5'd3,  OP_DIV  = 5'd4,  OP_SHR = 5'd5,
                           OP_SHL  = 5'd6,  OP_SHRA = 5'd7,  OP_ROR = 5'd8,
                           OP_ROL  = 5'd9,  OP_AND  = 5'd10, OP_OR  = 5'd11,
                           OP_NEG  = 5'd12, OP_XOR  = 5'd13, OP_NOR = 5'd14,
                           OP_NOT  = 5'd15;

    state_t            state_q, state_d;
    logic [SHW:0]      cnt_q, cnt_d;
    // acc: Booth partial product (sign-extended by one bit) / divider remainder.
    logic [WORD:0]     acc_q, acc_d;
    // q: multiplier being shifted out / dividend shifting into quotient.
    logic [WORD-1:0]   q_q, q_d;
    logic              q1_q, q1_d;
    // m: sign-extended multiplicand / divisor magnitude.
    logic [WORD:0]     m_q, m_d;
    logic [2*WORD-1:0] c_q, c_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [WORD:0]     booth_sum;

    logic [SHW-1:0]    sh;
    logic [WORD:0]     add_w, sub_w;
    logic [WORD-1:0]   ror_res, rol_res, shra_res;

    assign sh       = B[SHW-1:0];
    assign add_w    = {1'b0, A} + {1'b0, B};
    // Top bit of the difference is the unsigned borrow (A < B).
    assign sub_w    = {1'b0, A} - {1'b0, B};
    assign ror_res  = WORD'({A, A} >> sh);
    assign rol_res  = WORD'(({A, A} << sh) >> WORD);
    assign shra_res = $unsigned($signed(A) >>> sh);

`ifdef ALU_SEQ_DIV_EN
    logic            sq_q, sq_d;   // quotient negative
    logic            sr_q, sr_d;   // remainder negative (follows dividend)
    logic            dz_q, dz_d;   // divide by zero
    logic [WORD-1:0] amag, bmag;
    logic [WORD:0]   rshift, rdiff;

    assign amag   = A[WORD-1] ? -A : A;
    assign bmag   = B[WORD-1] ? -B : B;
    assign rshift = {acc_q[WORD-1:0], q_q[WORD-1]};
    assign rdiff  = rshift - m_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        c_d       = c_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
        booth_sum = acc_q;
`ifdef ALU_SEQ_DIV_EN
        sq_d      = sq_q;
        sr_d      = sr_q;
        dz_d      = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Single-cycle default: result now, high half zero.
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    err_d  = 1'b0;
                    c_d    = {{WORD{1'b0}}, A};
                    case (opcode)
                        OP_NOP:  c_d = {{WORD{1'b0}}, A};
                        OP_ADD:  c_d = {{(WORD-1){1'b0}}, add_w};
                        OP_SUB:  c_d = {{(WORD-1){1'b0}}, sub_w};
                        OP_MUL: begin
                            done_d  = 1'b0;
                            busy_d  = 1'b1;
                            c_d     = c_q;
                            err_d   = err_q;
                            acc_d   = '0;
                            q_d     = A;
                            q1_d    = 1'b0;
                            m_d     = {B[WORD-1], B};
                            cnt_d   = (SHW+1)'(WORD);
                            state_d = S_MUL;
                        end
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV: begin
                            done_d = 1'b0;
                            busy_d = 1'b1;
                            c_d    = c_q;
                            err_d  = err_q;
                            if (B == '0) begin
                                // FIX then emits {A, all-ones} unchanged.
                                acc_d   = {1'b0, A};
                                q_d     = '1;
                                sq_d    = 1'b0;
                                sr_d    = 1'b0;
                                dz_d    = 1'b1;
                                state_d = S_FIX;
                            end else begin
                                acc_d   = '0;
                                q_d     = amag;
                                m_d     = {1'b0, bmag};
                                sq_d    = A[WORD-1] ^ B[WORD-1];
                                sr_d    = A[WORD-1];
                                dz_d    = 1'b0;
                                cnt_d   = (SHW+1)'(WORD);
                                state_d = S_DIV;
                            end
                        end
`else
                        OP_DIV: begin
                            c_d   = '0;
                            err_d = 1'b1;
                        end
`endif
                        OP_SHR:  c_d = {{WORD{1'b0}}, A >> sh};
                        OP_SHL:  c_d = {{WORD{1'b0}}, A << sh};
                        OP_SHRA: c_d = {{WORD{1'b0}}, shra_res};
                        OP_ROR:  c_d = {{WORD{1'b0}}, ror_res};
                        OP_ROL:  c_d = {{WORD{1'b0}}, rol_res};
                        OP_AND:  c_d = {{WORD{1'b0}}, A & B};
                        OP_OR:   c_d = {{WORD{1'b0}}, A | B};
                        OP_NEG:  c_d = {{WORD{1'b0}}, -A};
                        OP_XOR:  c_d = {{WORD{1'b0}}, A ^ B};
                        OP_NOR:  c_d = {{WORD{1'b0}}, ~(A | B)};
                        OP_NOT:  c_d = {{WORD{1'b0}}, ~A};
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                case ({q_q[0], q1_q})
                    2'b01:   booth_sum = acc_q + m_q;
                    2'b10:   booth_sum = acc_q - m_q;
                    default: booth_sum = acc_q;
                endcase
                // Arithmetic right shift of {acc, q, q1}.
                acc_d = {booth_sum[WORD], booth_sum[WORD:1]};
                q_d   = {booth_sum[0], q_q[WORD-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b0;
                    c_d     = {acc_d[WORD-1:0], q_d};
                end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                // Restoring step: keep the trial subtraction only if non-negative.
                if (!rdiff[WORD]) begin
                    acc_d = {1'b0, rdiff[WORD-1:0]};
                    q_d   = {q_q[WORD-2:0], 1'b1};
                end else begin
                    acc_d = rshift;
                    q_d   = {q_q[WORD-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = dz_q;
                c_d     = {sr_q ? -acc_q[WORD-1:0] : acc_q[WORD-1:0],
                           sq_q ? -q_q : q_q};
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            c_q     <= c_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_DIV_EN
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign C         = c_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WORD=32). Stimulus is issued by driver tasks that push the
// expected C/err/completion offset into queues; a monitor pops and compares on
// every done pulse, and tracks the expected busy level every cycle.
// Completion offset = number of edges between the accept edge and the edge
// that registers done (0 for single-cycle ops).
module tb_alu_seq;
    localparam int W = 32;

    logic           clk;
    logic           clr;
    logic           start;
    logic [4:0]     opcode;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*W-1:0] c_out;
    logic [1:0]     dbg_state;

    alu_seq #(.WORD(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .opcode    (opcode),
        .A         (a_in),
        .B         (b_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .C         (c_out),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state
    logic [2*W-1:0] exp_q[$];
    logic           exp_err_q[$];
    int             acc_cyc_q[$];
    int             off_q[$];
    int             checks = 0;
    int             errors = 0;
    int             busy_start = 0;
    int             busy_end = 0;
    bit             mon_en = 1'b0;

`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor
    always begin
        logic [2*W-1:0] ec;
        logic           ee;
        int             ac;
        int             off;
        @(posedge clk);
        #1;
        if (mon_en) begin
            chk("busy", {{(2*W-1){1'b0}}, busy},
                {{(2*W-1){1'b0}}, (cyc >= busy_start && cyc < busy_end)});
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 C=%h, required no done", c_out);
                end else begin
                    ec  = exp_q.pop_front();
                    ee  = exp_err_q.pop_front();
                    ac  = acc_cyc_q.pop_front();
                    off = off_q.pop_front();
                    chk("C", c_out, ec);
                    chk("err", {{(2*W-1){1'b0}}, err}, {{(2*W-1){1'b0}}, ee});
                    chk("latency", 64'(cyc - ac), 64'(off));
                end
            end
        end
    end

    // driver: wait for busy=0, present one request, push its expectation
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] ec,
                         input logic ee, input int off);
        int waited = 0;
        @(negedge clk);
        while (busy !== 1'b0 && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%b, required 0 within 200 cycles", busy);
            return;
        end
        start  = 1'b1;
        opcode = op;
        a_in   = a;
        b_in   = b;
        exp_q.push_back(ec);
        exp_err_q.push_back(ee);
        acc_cyc_q.push_back(cyc + 1);
        off_q.push_back(off);
        if (off > 0) begin
            busy_start = cyc + 1;
            busy_end   = cyc + 1 + off;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int t;
        clr    = 1'b0;
        start  = 1'b0;
        opcode = 5'd0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        chk("rst_C", c_out, 64'h0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        mon_en = 1'b1;

        // add with carry out
        issue(5'b00001, 32'hFFFFFFFF, 32'h1, 64'h00000001_00000000, 1'b0, 0);

        // mul -3 * 7, with an ignored sub request mid-operation
        issue(5'b00011, 32'hFFFFFFFD, 32'h7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, W);
        repeat (5) @(negedge clk);
        chk("mul_state", {62'd0, dbg_state}, 64'd1);
        start  = 1'b1;
        opcode = 5'b00010;
        a_in   = 32'h1;
        b_in   = 32'h2;
        @(posedge clk);
        #1;
        start = 1'b0;

        // mul boundaries
        issue(5'b00011, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, W);
        issue(5'b00011, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b0, W);

        // div -7 / 2, then sub accepted back-to-back in the done cycle
        if (DIV_EN) issue(5'b00100, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, W + 1);
        else        issue(5'b00100, 32'hFFFFFFF9, 32'h2, 64'h0, 1'b1, 0);
        issue(5'b00010, 32'h5, 32'h7, 64'h00000001_FFFFFFFE, 1'b0, 0);

        // more div signs / boundary
        if (DIV_EN) begin
            issue(5'b00100, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, W + 1);
            issue(5'b00100, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, W + 1);
        end

        // divide by zero
        if (DIV_EN) issue(5'b00100, 32'h5, 32'h0, 64'h00000005_FFFFFFFF, 1'b1, 1);
        else        issue(5'b00100, 32'h5, 32'h0, 64'h0, 1'b1, 0);

        // shifts / rotates / logic / unassigned
        issue(5'b01000, 32'h80000001, 32'd33, 64'h00000000_C0000000, 1'b0, 0);
        issue(5'b00111, 32'h80000000, 32'd4,  64'h00000000_F8000000, 1'b0, 0);
        issue(5'b10101, 32'h00001234, 32'h9,  64'h00000000_00001234, 1'b1, 0);
        issue(5'b01001, 32'h80000001, 32'd1,  64'h00000000_00000003, 1'b0, 0);
        issue(5'b01000, 32'h12345678, 32'd32, 64'h00000000_12345678, 1'b0, 0);
        issue(5'b00101, 32'h80000000, 32'd36, 64'h00000000_08000000, 1'b0, 0);
        issue(5'b00110, 32'h00000001, 32'd31, 64'h00000000_80000000, 1'b0, 0);
        issue(5'b01010, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1'b0, 0);
        issue(5'b01011, 32'hF0F0F0F0, 32'h0F000F00, 64'h00000000_FFF0FFF0, 1'b0, 0);
        issue(5'b01100, 32'h00000005, 32'h0,  64'h00000000_FFFFFFFB, 1'b0, 0);
        issue(5'b01101, 32'hFFFF0000, 32'hFF00FF00, 64'h00000000_00FFFF00, 1'b0, 0);
        issue(5'b01110, 32'hF0F0F0F0, 32'h0F0F0F00, 64'h00000000_0000000F, 1'b0, 0);
        issue(5'b01111, 32'h0000FFFF, 32'h0,  64'h00000000_FFFF0000, 1'b0, 0);
        issue(5'b00000, 32'hDEADBEEF, 32'h1,  64'h00000000_DEADBEEF, 1'b0, 0);

        // clear 10 cycles into a mul: result discarded, no done follows
        issue(5'b00011, 32'h00000003, 32'h00000005, 64'h0, 1'b0, W);
        repeat (9) @(negedge clk);
        clr = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        acc_cyc_q.delete();
        off_q.delete();
        busy_end = cyc + 1;
        @(posedge clk);
        #1;
        chk("clr_C", c_out, 64'h0);
        chk("clr_done", {63'd0, done}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        clr = 1'b1;
        repeat (40) @(negedge clk);
        issue(5'b00001, 32'h2, 32'h3, 64'h00000000_00000005, 1'b0, 0);

        // drain
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: successor to the single-cycle ALU in the datapath. It executes the same 5-bit opcode set on `WORD`-bit operands and returns a `2*WORD`-bit result. Single-cycle ops complete in one cycle. Multiply and divide are iterative, signed and multi-cycle. The control unit drives it through a start/busy/done handshake instead of waiting a fixed number of cycles.

## Interface
- `WORD`, default 32: operand width; must be ≥ 4 and a power of two.
- `SHW`, default `$clog2(WORD)`: shift-amount width (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `opcode`  in  5  operation, sampled with `start`.
- `A`, `B`  in  WORD  operands, sampled with `start`.
- `busy`  out  1  operation in progress; reset 0.
- `done`  out  1  one-cycle pulse, `C`/`err` valid; reset 0.
- `err`  out  1  valid with `done`: divide-by-zero or unassigned/compiled-out opcode; reset 0.
- `C`  out  2*WORD  result, held until the next `done`; reset 0.

## Operation
- Opcodes: 00000 nop, 00001 add, 00010 sub, 00011 mul, 00100 div, 00101 shr, 00110 shl, 00111 shra, 01000 ror, 01001 rol, 01010 and, 01011 or, 01100 neg, 01101 xor, 01110 nor, 01111 not. Codes 10000–11111 are unassigned.
- Accept: `start`=1 and `busy`=0 at a rising edge latches `opcode`, `A` and `B`. `start` while `busy`=1 is ignored, with no queueing.
- Low half `C[WORD-1:0]` carries the result. High half is 0 except:
  - add: `C[WORD]` = carry-out.
  - sub: `C[WORD]` = borrow (A < B unsigned).
  - mul and div: see below.
- Shift and rotate amount is `B[SHW-1:0]`; upper bits of `B` are ignored. Rotate by 0 returns `A`. shra is arithmetic.
- nop returns `C = {0, A}` with `err`=0. Unassigned opcodes return `C = {0, A}` with `err`=1.
- mul: radix-2 Booth, signed × signed. `C` is the full `2*WORD` signed product.
- div: restoring divide on magnitudes, then sign fix. Quotient truncates toward zero. Remainder takes the dividend's sign. Result `C = {remainder, quotient}`.
- Divide by zero: no iteration. `C = {A, all-ones}`, `err`=1.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on accepted mul.
  - IDLE→DIV on accepted div with `B`≠0.
  - IDLE→FIX on div with `B`=0.
  - MUL→IDLE after `WORD` iterations.
  - DIV→FIX after `WORD` iterations.
  - FIX→IDLE.
  - All other accepted ops stay in IDLE.
- Iteration counter is `SHW+1` bits, loaded with `WORD` and decremented once per iteration. The state exits on count 1, so exactly `WORD` iterations run.
- `clr`=0 at any edge: state→IDLE, counter, `C`, `done`, `busy` and `err` all cleared. Any in-flight op is discarded.

## Timing
- Accept at edge k.
- Single-cycle ops: `C`, `done` and `err` are registered at edge k. Latency 1. `busy` stays 0.
- mul: iterations at edges k+1…k+`WORD`. `C`/`done` are registered at edge k+`WORD`.
- div: iterations at edges k+1…k+`WORD`, FIX at edge k+`WORD`+1. `C`/`done` are registered at that edge. Latency `WORD`+2.
- div by zero: FIX at edge k+1. Latency 2.
- `busy` is 1 from edge k up to, but not including, the edge that raises `done`. `busy` is 0 in the `done` cycle, so a new `start` may be accepted in the `done` cycle (back-to-back).
- `done` is 0 in every cycle except the single result cycle.

## Configuration
- `ALU_SEQ_DIV_EN`:
  - Defined: divider datapath, DIV state and FIX state are present, as specified above.
  - Undefined: no divider logic is built. Opcode 00100 completes in 1 cycle with `C`=0 and `err`=1.

## Test plan
- Reset, then add A=0xFFFFFFFF, B=1 (WORD=32) → `C`=0x00000001_00000000, `done` 1 cycle after accept, `busy` never 1.
- mul A=0xFFFFFFFD (−3), B=7 → `C`=0xFFFFFFFF_FFFFFFEB, `done` exactly 32 edges after accept; a `start` asserted with sub mid-operation is ignored.
- div A=0xFFFFFFF9 (−7), B=2 → `C`=0xFFFFFFFF_FFFFFFFD (rem −1, quot −3), latency 34, `err`=0. A second op accepted in the `done` cycle completes normally.
- div A=5, B=0 → `C`=0x00000005_FFFFFFFF, `err`=1, latency 2. With `ALU_SEQ_DIV_EN` undefined → `C`=0, `err`=1, latency 1.
- ror A=0x80000001, B=33 → `C`=0x00000000_C0000000. shra A=0x80000000, B=4 → `C` low half 0xF8000000. Opcode 10101 → `C`={0,A}, `err`=1.
- `clr` low 10 cycles into a mul → next edge `busy`=0, `C`=0, `done`=0. No `done` pulse follows. A new add is then accepted normally.
